// File: rtl/icache_block_fill_responder.sv
// Instruction-cache block-fill responder: gathers one cache line from word-wide
// memory with sequential Wishbone-classic reads and returns it as one wide block.
module icache_block_fill_responder #(
  parameter  int L2_BLOCK_SIZE = 6,
  parameter  int L2_ADDR_SIZE  = 5,
  parameter  int L2_DATA_SIZE  = 2,
  localparam int AW            = 1 << L2_ADDR_SIZE,
  localparam int W             = 1 << (L2_DATA_SIZE + 3),
  localparam int BW            = 1 << (L2_BLOCK_SIZE + 3)
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic [AW-1:0] ADR_I,
  output logic [BW-1:0] DAT_O,
  output logic          ACK_O,
  output logic          mem_CYC_O,
  output logic          mem_STB_O,
  output logic [AW-1:0] mem_ADR_O,
  input  logic [W-1:0]  mem_DAT_I,
  input  logic          mem_ACK_I
);

  localparam int NB = L2_BLOCK_SIZE - L2_DATA_SIZE;
  localparam int N  = 1 << NB;
  localparam int CW = (NB < 1) ? 1 : NB;
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [AW-1:0] BLK_MASK = ~AW'((1 << L2_BLOCK_SIZE) - 1);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_inc;
  logic [AW-1:0]          base_q;
  logic [AW-1:0]          adr_q;
  logic [N-1:0][W-1:0]    dat_q;
  logic                   req;
  logic                   last_beat;

  assign req       = CYC_I && STB_I;
  assign cnt_inc   = cnt_q + CW'(1);
  assign last_beat = (cnt_q == LAST);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = FETCH;
      FETCH: begin
        // Dropping CYC_I wins over a final-beat acknowledge: no block is returned.
        if (!CYC_I)                       state_d = IDLE;
        else if (mem_ACK_I && last_beat)  state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Base has zero offset bits, so OR-ing the word offset never carries into the tag.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cnt_q  <= '0;
      base_q <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            base_q <= ADR_I & BLK_MASK;
            adr_q  <= ADR_I & BLK_MASK;
            cnt_q  <= '0;
          end
        end
        FETCH: begin
          if (mem_ACK_I) dat_q[cnt_q] <= mem_DAT_I;
          if (!CYC_I) begin
            cnt_q <= '0;
          end else if (mem_ACK_I && !last_beat) begin
            cnt_q <= cnt_inc;
            adr_q <= base_q | (AW'(cnt_inc) << L2_DATA_SIZE);
          end
        end
        default: ;
      endcase
    end
  end

  assign DAT_O     = dat_q;
  assign ACK_O     = (state_q == RESP);
  assign mem_CYC_O = (state_q == FETCH);
  assign mem_STB_O = (state_q == FETCH);
  assign mem_ADR_O = adr_q;

endmodule

// File: tb/tb_icache_block_fill_responder.sv
// Bench for icache_block_fill_responder: directed scenarios with literal expectations
// plus randomized fills compared cycle by cycle against a transaction-level model.
module tb_icache_block_fill_responder;
  localparam int AW = 32;
  localparam int W  = 32;
  localparam int BW = 512;
  localparam int N  = 16;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic          CYC_I = 1'b0;
  logic          STB_I = 1'b0;
  logic [AW-1:0] ADR_I = '0;
  logic [BW-1:0] DAT_O;
  logic          ACK_O;
  logic          mem_CYC_O;
  logic          mem_STB_O;
  logic [AW-1:0] mem_ADR_O;
  logic [W-1:0]  mem_DAT_I = '0;
  logic          mem_ACK_I = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK_I = ~CLK_I;

  icache_block_fill_responder dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .ADR_I(ADR_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O), .mem_CYC_O(mem_CYC_O), .mem_STB_O(mem_STB_O),
    .mem_ADR_O(mem_ADR_O), .mem_DAT_I(mem_DAT_I), .mem_ACK_I(mem_ACK_I)
  );

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: acknowledges each new address after wtarget extra cycles, data = address ^ salt.
  int            mem_waits = 0;
  bit            rand_mem  = 1'b0;
  logic [31:0]   salt      = '0;
  logic [31:0]   cur_adr   = '0;
  bit            prev_stb  = 1'b0;
  int            wcnt      = 0;
  int            wtarget   = 0;
  logic [31:0]   acked_q[$];

  always @(posedge CLK_I) begin
    #1;
    if (mem_STB_O === 1'b1) begin
      if (!prev_stb || mem_ADR_O !== cur_adr) begin
        cur_adr = mem_ADR_O;
        wcnt    = 0;
        wtarget = rand_mem ? int'($urandom_range(0, 3)) : mem_waits;
      end
      mem_ACK_I = (wcnt >= wtarget);
      mem_DAT_I = mem_ADR_O ^ salt;
      if (mem_ACK_I) acked_q.push_back(mem_ADR_O);
      wcnt++;
      prev_stb = 1'b1;
    end else begin
      prev_stb  = 1'b0;
      mem_ACK_I = rand_mem && ($urandom_range(0, 3) == 0);
      mem_DAT_I = $urandom;
    end
  end

  // Transaction-level reference: a fill in progress, the beat it waits on, the block so far.
  bit                  m_busy = 1'b0;
  bit                  m_resp = 1'b0;
  logic [31:0]         m_base = '0;
  int                  m_beat = 0;
  logic [N-1:0][W-1:0] m_blk  = '0;

  always @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      m_busy = 1'b0; m_resp = 1'b0; m_base = '0; m_beat = 0; m_blk = '0;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_busy) begin
      if (mem_ACK_I) m_blk[m_beat] = mem_DAT_I;
      if (!CYC_I) m_busy = 1'b0;
      else if (mem_ACK_I) begin
        if (m_beat == N - 1) begin
          m_busy = 1'b0;
          m_resp = 1'b1;
        end else begin
          m_beat++;
        end
      end
    end else if (CYC_I && STB_I) begin
      m_busy = 1'b1;
      m_base = ADR_I & ~32'h3F;
      m_beat = 0;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge CLK_I) begin
    if (chk_en && !RST_I) begin
      check("ACK_O", ACK_O, m_resp);
      check("mem_STB_O", mem_STB_O, m_busy);
      check("mem_CYC_O", mem_CYC_O, m_busy);
      if (m_busy) check("mem_ADR_O", mem_ADR_O, m_base + 32'(m_beat) * 4);
      check("DAT_O", DAT_O, m_blk);
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #2;
  endtask

  // lat counts the request edge as 1 and stops at the edge that raised ACK_O.
  task automatic wait_ack(output int lat);
    lat = 1;
    while (!ACK_O && lat < 400) begin
      tick();
      lat++;
    end
    if (!ACK_O) begin
      nvec++;
      nerr++;
      $display("FAIL ack timeout: ACK_O still low after %0d cycles", lat);
    end
  endtask

  task automatic check_block(input string tag, input logic [31:0] base);
    check({tag, " beats"}, acked_q.size(), N);
    for (int k = 0; k < N; k++) begin
      check({tag, " word"}, DAT_O[k*W +: W], base + 32'(k) * 4);
      if (k < acked_q.size()) check({tag, " mem addr"}, acked_q[k], base + 32'(k) * 4);
    end
  endtask

  task automatic fill(input logic [31:0] adr, input int exp_lat, input string tag);
    int lat;
    acked_q.delete();
    CYC_I = 1'b1; STB_I = 1'b1; ADR_I = adr;
    tick();
    wait_ack(lat);
    CYC_I = 1'b0; STB_I = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check_block(tag, adr & ~32'h3F);
  endtask

  initial begin
    int lat;
    int n;
    int abort_at;
    bit b2b;

    // Reset asserted between edges clears everything at once.
    #2 RST_I = 1'b1;
    #1;
    check("reset DAT_O", DAT_O, '0);
    check("reset ACK_O", ACK_O, 1'b0);
    check("reset mem_CYC_O", mem_CYC_O, 1'b0);
    check("reset mem_STB_O", mem_STB_O, 1'b0);
    check("reset mem_ADR_O", mem_ADR_O, '0);
    repeat (3) begin
      @(posedge CLK_I); #1;
      check("reset hold ACK_O", ACK_O, 1'b0);
      check("reset hold mem_STB_O", mem_STB_O, 1'b0);
    end
    #1 RST_I = 1'b0;
    chk_en = 1'b1;
    tick();

    fill(32'h0000_1234, 17, "zero-wait");
    tick();

    mem_waits = 2;
    fill(32'h0000_1234, 49, "wait-state");
    mem_waits = 0;
    tick();

    // Abort after beat 5; the CYC_I drop coincides with the beat-6 acknowledge.
    acked_q.delete();
    CYC_I = 1'b1; STB_I = 1'b1; ADR_I = 32'h0000_5000;
    tick();
    repeat (6) tick();
    CYC_I = 1'b0; STB_I = 1'b0;
    tick();
    check("abort mem_CYC_O", mem_CYC_O, 1'b0);
    check("abort ACK_O", ACK_O, 1'b0);
    for (int k = 0; k < 7; k++) check("abort kept word", DAT_O[k*W +: W], 32'h5000 + 32'(k) * 4);
    repeat (3) begin
      tick();
      check("abort no ACK_O", ACK_O, 1'b0);
    end
    fill(32'h0000_0040, 17, "after-abort");
    tick();

    // Back-to-back: request held through ACK_O, address changed in the response cycle.
    acked_q.delete();
    CYC_I = 1'b1; STB_I = 1'b1; ADR_I = 32'h0000_0080;
    tick();
    wait_ack(lat);
    check("b2b first latency", lat, 17);
    check_block("b2b first", 32'h80);
    ADR_I = 32'h0000_00C0;
    acked_q.delete();
    tick();
    check("b2b idle ACK_O", ACK_O, 1'b0);
    check("b2b idle mem_STB_O", mem_STB_O, 1'b0);
    tick();
    check("b2b second first addr", mem_ADR_O, 32'hC0);
    wait_ack(lat);
    CYC_I = 1'b0; STB_I = 1'b0;
    check("b2b second latency", lat, 17);
    check_block("b2b second", 32'hC0);
    tick();

    // Reset in the middle of a fill.
    CYC_I = 1'b1; STB_I = 1'b1; ADR_I = 32'h0000_2000;
    tick();
    repeat (8) tick();
    #1 RST_I = 1'b1;
    #1;
    check("midreset DAT_O", DAT_O, '0);
    check("midreset mem_STB_O", mem_STB_O, 1'b0);
    check("midreset ACK_O", ACK_O, 1'b0);
    check("midreset mem_ADR_O", mem_ADR_O, '0);
    CYC_I = 1'b0; STB_I = 1'b0;
    tick();
    tick();
    RST_I = 1'b0;
    tick();
    fill(32'h0000_1000, 17, "post-reset");
    tick();

    // Randomized fills: random waits, stray acks, aborts, bus noise, back-to-back requests.
    rand_mem = 1'b1;
    b2b = 1'b0;
    repeat (60) begin
      salt     = $urandom;
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : 0;
      CYC_I = 1'b1; STB_I = 1'b1; ADR_I = $urandom;
      if (b2b) tick();
      tick();
      n = 1;
      while (!ACK_O && n < 400) begin
        if (abort_at != 0 && n == abort_at) break;
        if (m_busy) begin
          STB_I = 1'($urandom_range(0, 1));
          ADR_I = $urandom;
        end
        tick();
        n++;
      end
      if (n >= 400) begin
        nvec++;
        nerr++;
        $display("FAIL random fill timeout: ACK_O still low after %0d cycles", n);
      end
      b2b = ACK_O && ($urandom_range(0, 3) == 0);
      if (!b2b) begin
        CYC_I = 1'b0; STB_I = 1'b0; ADR_I = $urandom;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    CYC_I = 1'b0; STB_I = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/icache_block_fill_responder.md
Name: icache_block_fill_responder

Overview:
- Responder side of the instruction cache's block-fill request: serves a full cache line to the cache controller/datapath over a Wishbone-classic slave port.
- Builds each line by issuing sequential word reads to narrow main memory over a Wishbone-classic master port.
- Assembles 2^(L2_BLOCK_SIZE-L2_DATA_SIZE) words into one wide block and returns it with a single-cycle ACK_O.
- Sits between the cache's wide block interface (block address out, block data in) and the word-wide memory bus.

Parameters:
L2_BLOCK_SIZE, 6, log2(block size in bytes); block width BW = 2^(L2_BLOCK_SIZE+3) bits
L2_ADDR_SIZE, 5, log2(address width in bits); AW = 2^L2_ADDR_SIZE
L2_DATA_SIZE, 2, log2(memory word size in bytes); word width W = 2^(L2_DATA_SIZE+3), N = 2^(L2_BLOCK_SIZE-L2_DATA_SIZE) words per block

Ports:
CLK_I  in  1  clock, all state changes on rising edge
RST_I  in  1  reset, asynchronous, active-high
CYC_I  in  1  cache-side cycle valid
STB_I  in  1  cache-side strobe (block request)
ADR_I  in  AW  requested byte address; low L2_BLOCK_SIZE bits ignored
DAT_O  out  BW  assembled block; word k at bits [(k+1)*W-1 : k*W]
ACK_O  out  1  block ready, one-cycle pulse
mem_CYC_O  out  1  memory-side cycle
mem_STB_O  out  1  memory-side strobe
mem_ADR_O  out  AW  memory word address
mem_DAT_I  in  W  memory read data
mem_ACK_I  in  1  memory read acknowledge

Behaviour:
- States: IDLE, FETCH, RESP. Reset (async): state=IDLE, counter=0, base=0, DAT_O=0, ACK_O=0, mem_CYC_O=0, mem_STB_O=0, mem_ADR_O=0.
- IDLE: all strobes low. On edge with CYC_I&STB_I: base <= {ADR_I[AW-1:L2_BLOCK_SIZE], zeros}, counter <= 0, -> FETCH.
- FETCH: mem_CYC_O=mem_STB_O=1 continuously; mem_ADR_O = base + (counter << L2_DATA_SIZE), registered/stable until mem_ACK_I.
  - Edge with mem_ACK_I: DAT_O word[counter] <= mem_DAT_I. If counter==N-1 -> RESP, else counter++.
  - New address presented the cycle after each ACK. Zero-wait memory (ACK same cycle as STB) gives one beat per cycle.
- RESP: ACK_O=1 for exactly one cycle; mem strobes low; -> IDLE. DAT_O stable from RESP until the first beat of the next fill.
- Latency with zero-wait memory: request sampled edge 0; beats captured edges 1..N; ACK_O high in the cycle after edge N. Each memory wait cycle adds one cycle.
- Offset arithmetic never carries into the tag/index bits: counter < N, base low bits zero. Counter width = L2_BLOCK_SIZE-L2_DATA_SIZE bits (min 1).
- Abort: CYC_I low during FETCH -> next edge to IDLE, mem strobes low, no ACK_O, counter cleared. Words already written stay in DAT_O.
  - Simultaneous CYC_I drop and mem_ACK_I: word still captured, abort still taken.
- Back-to-back: CYC_I&STB_I still high in the IDLE cycle after RESP is a new request (full refill).
- mem_ACK_I outside FETCH: ignored. STB_I/ADR_I changes during FETCH/RESP: ignored; base latched.
- Reset mid-fill: immediate async return to reset values, including DAT_O=0.

Test Plan:
- Reset: assert RST_I between clock edges -> all outputs 0 immediately; hold 3 cycles -> ACK_O, mem_STB_O stay 0.
- Single fill, zero-wait memory returning data=address: ADR_I=0x0000_1234 -> mem_ADR_O steps 0x1200,0x1204,...,0x123C (16 beats, one per cycle); ACK_O high exactly 1 cycle, 17 cycles after request edge; DAT_O word k = 0x1200+4k.
- Wait states: memory ACKs 3 cycles after each strobe -> each mem_ADR_O held 3 cycles; ACK_O at request edge + 49 cycles; same DAT_O as zero-wait fill.
- Abort: drop CYC_I after beat 5 captured -> mem_CYC_O=0 next cycle, no ACK_O. New request ADR_I=0x40 -> addresses 0x40..0x7C, ACK_O normal.
- Back-to-back: hold CYC_I&STB_I through ACK_O with ADR_I=0x80 then 0xC0 -> second fill from 0xC0 starts from the IDLE cycle; two distinct ACK_O pulses.
- Reset mid-fill at beat 8 -> DAT_O=0, mem_STB_O=0 asynchronously. Release and request 0x1000 -> full 16-beat fill from 0x1000.
